// File: rtl/sar_pkg.sv
// -----------------------------------------------------------------------------
// sar_pkg
// Shared definitions for the successive-approximation searcher:
//   - one-hot magnitude-compare result codes {A>B, A<B, A=B}
//   - FSM state encoding (2-bit)
//   - one-hot validity check for a 3-bit compare code
// -----------------------------------------------------------------------------
package sar_pkg;

    localparam logic [2:0] CMP_GT = 3'b100;
    localparam logic [2:0] CMP_LT = 3'b010;
    localparam logic [2:0] CMP_EQ = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_DONE   = 2'd2
    } sar_state_t;

    function automatic logic cmp_is_onehot(input logic [2:0] code);
        return (code == CMP_GT) || (code == CMP_LT) || (code == CMP_EQ);
    endfunction

endpackage

// File: rtl/sar_search.sv
// -----------------------------------------------------------------------------
// sar_search
// Successive-approximation searcher. Drives a candidate onto a magnitude
// comparator's B input (target on A) and resolves the target MSB-first,
// one bit per clock, from the comparator's one-hot result.
//
// Parameters:
//   WIDTH    probe / result width, legal 2..16
//
// Ports:
//   iClk     in   1      rising-edge clock
//   iRst     in   1      asynchronous active-high reset
//   iStart   in   1      start request, sampled only in IDLE
//   iCmp     in   3      comparator result for oProbe (100 GT, 010 LT, 001 EQ)
//   oProbe   out  WIDTH  registered candidate for comparator B input
//   oBusy    out  1      high while searching
//   oDone    out  1      one-cycle pulse when oResult updates
//   oResult  out  WIDTH  resolved target, held until next completion
//   oErr     out  1      sticky: a non-one-hot iCmp was seen this search
//
// Optional build macro:
//   SAR_SEARCH_EARLY_EXIT_EN  an EQ answer finishes the search immediately
//                             with the current probe as the result.
// -----------------------------------------------------------------------------
module sar_search
    import sar_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iStart,
    input  logic [2:0]       iCmp,
    output logic [WIDTH-1:0] oProbe,
    output logic             oBusy,
    output logic             oDone,
    output logic [WIDTH-1:0] oResult,
    output logic             oErr
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] MSB_BIT = ONE << (WIDTH - 1);

    sar_state_t       r_state;
    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] r_probe;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_result;
    logic             r_err;

    logic [WIDTH-1:0] w_bit;
    logic [WIDTH-1:0] w_trial;
    logic             w_finish;

    // Only an explicit LT answer drops the bit under test; GT, EQ and any
    // malformed code keep it.
    assign w_bit   = ONE << r_idx;
    assign w_trial = (iCmp == CMP_LT) ? (r_probe & ~w_bit) : r_probe;

`ifdef SAR_SEARCH_EARLY_EXIT_EN
    // On EQ the trial equals the probe, so the same result path serves both
    // the early exit and the last-bit exit.
    assign w_finish = (r_idx == '0) || (iCmp == CMP_EQ);
`else
    assign w_finish = (r_idx == '0);
`endif

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_state  <= ST_IDLE;
            r_idx    <= IDX_MSB;
            r_probe  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done  <= 1'b0;
                    r_probe <= '0;
                    r_busy  <= 1'b0;
                    if (iStart) begin
                        r_state <= ST_SEARCH;
                        r_probe <= MSB_BIT;
                        r_idx   <= IDX_MSB;
                        r_err   <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_SEARCH: begin
                    if (!cmp_is_onehot(iCmp)) begin
                        r_err <= 1'b1;
                    end
                    if (w_finish) begin
                        r_result <= w_trial;
                        r_probe  <= '0;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= ST_DONE;
                    end else begin
                        r_probe <= w_trial | (w_bit >> 1);
                        r_idx   <= r_idx - IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_idx   <= IDX_MSB;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_probe <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign oProbe  = r_probe;
    assign oBusy   = r_busy;
    assign oDone   = r_done;
    assign oResult = r_result;
    assign oErr    = r_err;

endmodule

// File: tb/tb_sar_search.sv
// -----------------------------------------------------------------------------
// tb_sar_search
// Closed-loop bench: a 4-bit cascadable magnitude comparator (target on A,
// oProbe on B, cascade input tied to EQ) feeds iCmp. Accepted starts push an
// expected completion into a scoreboard queue; a monitor pops it on oDone and
// checks result, error flag, latency and the probe sequence.
// -----------------------------------------------------------------------------
module tb_sar_search;

    localparam int W = 4;

    logic         iClk = 1'b0;
    logic         iRst;
    logic         iStart;
    logic [2:0]   iCmp;
    logic [W-1:0] oProbe;
    logic         oBusy;
    logic         oDone;
    logic [W-1:0] oResult;
    logic         oErr;

    logic [W-1:0] target;
    logic         inject_en;
    logic [W-1:0] inject_probe;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int done_cnt    = 0;

    typedef struct {
        logic [W-1:0] tgt;
        logic         err;
        int           start_cyc;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] probes[$];

    sar_search #(.WIDTH(W)) dut (
        .iClk    (iClk),
        .iRst    (iRst),
        .iStart  (iStart),
        .iCmp    (iCmp),
        .oProbe  (oProbe),
        .oBusy   (oBusy),
        .oDone   (oDone),
        .oResult (oResult),
        .oErr    (oErr)
    );

    always #5 iClk = ~iClk;

    always @(posedge iClk) cyc <= cyc + 1;

    // 4-bit cascadable comparator: lower-significance cascade decides on a tie.
    function automatic logic [2:0] cmp4(input logic [3:0] a, input logic [3:0] b,
                                        input logic [2:0] cas);
        if (a > b)      return 3'b100;
        else if (a < b) return 3'b010;
        else            return cas;
    endfunction

    always_comb begin
        iCmp = cmp4(target, oProbe, 3'b001);
        if (inject_en && oBusy && (oProbe == inject_probe)) iCmp = 3'b110;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // k-th probe of an ideal binary search for t: bits above the tested bit
    // are already resolved to t, tested bit is 1, bits below are 0.
    function automatic logic [W-1:0] model_probe(input logic [W-1:0] t, input int k);
        int hi;
        int tv;
        int p;
        hi = W - 1 - k;
        tv = int'(t);
        p  = ((tv >> (hi + 1)) << (hi + 1)) + (1 << hi);
        return W'(p);
    endfunction

    function automatic int model_nprobes(input logic [W-1:0] t);
`ifdef SAR_SEARCH_EARLY_EXIT_EN
        for (int k = 0; k < W; k++) begin
            if (model_probe(t, k) == t) return k + 1;
        end
        return W;
`else
        return (t == t) ? W : W;
`endif
    endfunction

    // Scoreboard monitor and start acceptance.
    initial begin
        exp_t e;
        int   n;
        forever begin
            @(negedge iClk);
            if (!iRst) begin
                if (oBusy) probes.push_back(oProbe);
                if (oDone) begin
                    done_cnt++;
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_done: got oDone=1, expected 0 (cycle %0d)", cyc);
                    end else begin
                        e = exp_q.pop_front();
                        n = model_nprobes(e.tgt);
                        check("result", 32'(oResult), 32'(e.tgt));
                        check("err", 32'(oErr), 32'(e.err));
                        check("latency", 32'(cyc - e.start_cyc), 32'(n + 1));
                        check("probe_count", 32'(probes.size()), 32'(n));
                        for (int k = 0; k < n && k < probes.size(); k++) begin
                            check($sformatf("probe%0d", k), 32'(probes[k]), 32'(model_probe(e.tgt, k)));
                        end
                    end
                end
                if (iStart && !oBusy && !oDone) begin
                    exp_q.push_back('{tgt: target, err: inject_en, start_cyc: cyc});
                    probes.delete();
                end
            end
        end
    end

    task automatic wait_drain(input int max_cyc);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || oBusy || oDone) && n < max_cyc) begin
            @(posedge iClk); #2;
            n++;
        end
        if (n >= max_cyc) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout: got no completion within %0d cycles, expected one", max_cyc);
            exp_q.delete();
        end
    endtask

    task automatic run(input logic [W-1:0] t, input logic inj);
        @(posedge iClk); #2;
        target    = t;
        inject_en = inj;
        iStart    = 1'b1;
        @(posedge iClk); #2;
        iStart = 1'b0;
        wait_drain(30);
    endtask

    initial begin
        int d0;
        iRst         = 1'b1;
        iStart       = 1'b0;
        target       = '0;
        inject_en    = 1'b0;
        inject_probe = '0;
        repeat (3) @(posedge iClk);
        #2;
        check("rst_probe", 32'(oProbe), 0);
        check("rst_busy", 32'(oBusy), 0);
        check("rst_done", 32'(oDone), 0);
        check("rst_result", 32'(oResult), 0);
        check("rst_err", 32'(oErr), 0);
        iRst = 1'b0;

        run(4'b1011, 1'b0);
        run(4'b0000, 1'b0);
        run(4'b1111, 1'b0);
        run(4'b1000, 1'b0);

        // Malformed answer on the second probe.
        inject_probe = 4'b0100;
        run(4'b0101, 1'b1);
        inject_en = 1'b0;
        repeat (3) @(posedge iClk);
        #2;
        check("err_sticky", 32'(oErr), 1);
        run(4'b0011, 1'b0);
        check("err_cleared", 32'(oErr), 0);

        // Reset after two probes.
        @(posedge iClk); #2;
        target = 4'b1101;
        iStart = 1'b1;
        @(posedge iClk); #2;
        iStart = 1'b0;
        @(posedge iClk); #2;
        @(posedge iClk); #2;
        iRst = 1'b1;
        #1;
        check("abort_probe", 32'(oProbe), 0);
        check("abort_busy", 32'(oBusy), 0);
        check("abort_done", 32'(oDone), 0);
        check("abort_result", 32'(oResult), 0);
        check("abort_err", 32'(oErr), 0);
        exp_q.delete();
        @(posedge iClk); #2;
        iRst = 1'b0;
        d0 = done_cnt;
        repeat (8) @(posedge iClk);
        #2;
        check("abort_no_done", 32'(done_cnt - d0), 0);
        run(4'b0110, 1'b0);

        // Start held high for 20 cycles: starts on edges 1, 7, 13, 19.
        d0 = done_cnt;
        target = 4'b0000;
        iStart = 1'b1;
        repeat (20) begin
            @(posedge iClk); #2;
        end
        iStart = 1'b0;
        wait_drain(30);
        check("held_done_count", 32'(done_cnt - d0), 4);

        // Start pulses while searching are ignored.
        d0 = done_cnt;
        target = 4'b0011;
        iStart = 1'b1;
        @(posedge iClk); #2;
        @(posedge iClk); #2;
        iStart = 1'b0;
        @(posedge iClk); #2;
        iStart = 1'b1;
        @(posedge iClk); #2;
        iStart = 1'b0;
        wait_drain(30);
        check("busy_start_ignored", 32'(done_cnt - d0), 1);

        for (int i = 0; i < 20; i++) begin
            run(W'($urandom_range(0, (1 << W) - 1)), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish before 200000");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
